// File: rtl/armleocpu_fetch_responder.sv
// Responder side of the fetch cache interface: a direct-mapped,
// one-word-per-line instruction buffer refilled over a req/ack bus.
module armleocpu_fetch_responder #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  c_cmd,
    input  logic [31:0] c_address,
    output logic [3:0]  c_response,
    output logic        c_reset_done,
    output logic [31:0] c_load_data,
    output logic        m_req,
    output logic [31:0] m_addr,
    input  logic        m_ack,
    input  logic        m_err,
    input  logic [31:0] m_rdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

    localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
    localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd5;

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, REFILL, RESP, FLUSH
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic [29:0]        addr_l;
    logic [3:0]         resp_r;
    logic [31:0]        data_r;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags  [LINES];
    logic [31:0]        words [LINES];

    logic [IDX_W-1:0]   idx_l;
    logic [TAG_W-1:0]   tag_l;
    logic               hit;
    logic               accept;
    logic               last;
    logic               misal;

    assign idx_l = addr_l[IDX_W-1:0];
    assign tag_l = addr_l[29:IDX_W];
    assign hit   = valid[idx_l] && (tags[idx_l] == tag_l);
    assign last  = (cnt == IDX_W'(LINES - 1));
    assign misal = |c_address[1:0];

    always_comb begin
        c_response  = CACHE_RESPONSE_IDLE;
        c_load_data = data_r;
        unique case (state)
            INIT, IDLE: c_response = CACHE_RESPONSE_IDLE;
            LOOKUP: begin
                if (hit) begin
                    c_response  = CACHE_RESPONSE_DONE;
                    c_load_data = words[idx_l];
                end else begin
                    c_response  = CACHE_RESPONSE_WAIT;
                end
            end
            REFILL, FLUSH: c_response = CACHE_RESPONSE_WAIT;
            RESP: c_response = resp_r;
            default: c_response = CACHE_RESPONSE_IDLE;
        endcase
    end

    // Any terminal response frees the responder, so a new command
    // can be taken in the same cycle a result is delivered.
    assign accept = (state == IDLE)
        || (c_response == CACHE_RESPONSE_DONE)
        || (c_response == CACHE_RESPONSE_MISSALIGNED)
        || (c_response == CACHE_RESPONSE_ACCESSFAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            cnt          <= '0;
            c_reset_done <= 1'b0;
            addr_l       <= '0;
            resp_r       <= CACHE_RESPONSE_IDLE;
            data_r       <= '0;
            m_req        <= 1'b0;
            m_addr       <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (last) begin
                state        <= IDLE;
                c_reset_done <= 1'b1;
            end
        end else if (accept) begin
            unique case (1'b1)
                (c_cmd == CACHE_CMD_EXECUTE) && misal: begin
                    state  <= RESP;
                    resp_r <= CACHE_RESPONSE_MISSALIGNED;
                end
                (c_cmd == CACHE_CMD_EXECUTE) && !misal: begin
                    addr_l <= c_address[31:2];
                    state  <= LOOKUP;
                end
                (c_cmd == CACHE_CMD_FLUSH_ALL): begin
                    cnt   <= '0;
                    state <= FLUSH;
                end
                default: state <= IDLE;
            endcase
        end else begin
            unique case (state)
                LOOKUP: begin
                    m_req  <= 1'b1;
                    m_addr <= {addr_l, 2'b00};
                    state  <= REFILL;
                end
                REFILL: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= RESP;
                        if (m_err) begin
                            resp_r <= CACHE_RESPONSE_ACCESSFAULT;
                        end else begin
                            resp_r <= CACHE_RESPONSE_DONE;
                            data_r <= m_rdata;
                        end
                    end
                end
                FLUSH: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state  <= RESP;
                        resp_r <= CACHE_RESPONSE_DONE;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Line storage has no reset; INIT sweeps the valid bits instead.
    always_ff @(posedge clk) begin
        if (state == INIT || state == FLUSH) begin
            valid[cnt] <= 1'b0;
        end
        if (state == REFILL && m_ack && !m_err) begin
            valid[idx_l] <= 1'b1;
            tags[idx_l]  <= tag_l;
            words[idx_l] <= m_rdata;
        end
    end

endmodule

// File: tb/tb_armleocpu_fetch_responder.sv
// Directed bench for armleocpu_fetch_responder with a response
// scoreboard fed at issue time and drained at each terminal response.
module tb_armleocpu_fetch_responder;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] EXEC  = 4'd1;
    localparam logic [3:0] FLUSH = 4'd4;

    localparam logic [3:0] R_IDLE = 4'd0;
    localparam logic [3:0] R_WAIT = 4'd1;
    localparam logic [3:0] R_DONE = 4'd2;
    localparam logic [3:0] R_AF   = 4'd3;
    localparam logic [3:0] R_MIS  = 4'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  c_cmd = NONE;
    logic [31:0] c_address = '0;
    logic [3:0]  c_response;
    logic        c_reset_done;
    logic [31:0] c_load_data;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_ack = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_rdata = '0;

    armleocpu_fetch_responder #(.LINES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .c_cmd        (c_cmd),
        .c_address    (c_address),
        .c_response   (c_response),
        .c_reset_done (c_reset_done),
        .c_load_data  (c_load_data),
        .m_req        (m_req),
        .m_addr       (m_addr),
        .m_ack        (m_ack),
        .m_err        (m_err),
        .m_rdata      (m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  resp;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] addr,
                         input logic [3:0] resp, input logic [31:0] data,
                         input bit chk);
        c_cmd = cmd;
        c_address = addr;
        sb.push_back('{resp, data, chk});
    endtask

    task automatic expect_term(input string tag, input logic [3:0] wait_cmd,
                               input int ack_delay, input logic [31:0] rdata,
                               input bit err, input logic [31:0] exp_addr,
                               output int lat, output bit saw_req);
        int mcnt;
        bit done;
        exp_t e;
        mcnt = 0;
        done = 1'b0;
        lat = 0;
        saw_req = 1'b0;
        while (!done && lat < 60) begin
            tick();
            lat++;
            if (c_response == R_WAIT) begin
                c_cmd = wait_cmd;
                if (m_req) begin
                    saw_req = 1'b1;
                    mcnt++;
                    check({tag, "_maddr"}, m_addr, exp_addr);
                    if (mcnt == ack_delay) begin
                        m_ack = 1'b1;
                        m_err = err;
                        m_rdata = rdata;
                    end
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed WAIT expected terminal", tag);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed response %h expected none", tag,
                   c_response);
        end else begin
            e = sb.pop_front();
            check({tag, "_resp"}, c_response, e.resp);
            if (e.chk) check({tag, "_data"}, c_load_data, e.data);
            check({tag, "_mreq_off"}, m_req, 0);
        end
    endtask

    initial begin
        int lat;
        bit sr;

        repeat (3) tick();
        check("rst_resp", c_response, R_IDLE);
        check("rst_done", c_reset_done, 0);
        check("rst_mreq", m_req, 0);
        check("rst_maddr", m_addr, 0);
        check("rst_data", c_load_data, 0);

        rst_n = 1'b1;
        c_cmd = EXEC;
        c_address = 32'h2000;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("init_done", c_reset_done, (i == 16));
            check("init_resp", c_response, R_IDLE);
        end
        c_cmd = NONE;
        tick();
        check("init_cmd_ignored", c_response, R_IDLE);
        check("init_mreq", m_req, 0);

        issue(EXEC, 32'h2000, R_DONE, 32'h0000_0013, 1);
        expect_term("cold", EXEC, 3, 32'h0000_0013, 0, 32'h2000, lat, sr);
        check("cold_lat", lat, 5);
        check("cold_req", sr, 1);

        issue(EXEC, 32'h2000, R_DONE, 32'h0000_0013, 1);
        expect_term("hit", EXEC, 0, 0, 0, 0, lat, sr);
        check("hit_lat", lat, 1);
        check("hit_noreq", sr, 0);

        issue(EXEC, 32'h2004, R_DONE, 32'h0010_0093, 1);
        expect_term("miss4", EXEC, 1, 32'h0010_0093, 0, 32'h2004, lat, sr);
        check("miss4_lat", lat, 3);

        issue(EXEC, 32'h2000, R_DONE, 32'h0000_0013, 1);
        expect_term("b2b0", EXEC, 0, 0, 0, 0, lat, sr);
        check("b2b0_lat", lat, 1);
        issue(EXEC, 32'h2004, R_DONE, 32'h0010_0093, 1);
        expect_term("b2b1", EXEC, 0, 0, 0, 0, lat, sr);
        check("b2b1_lat", lat, 1);
        check("b2b1_noreq", sr, 0);

        issue(EXEC, 32'h2002, R_MIS, 0, 0);
        expect_term("misal", EXEC, 0, 0, 0, 0, lat, sr);
        check("misal_lat", lat, 1);
        check("misal_noreq", sr, 0);

        issue(EXEC, 32'h3000, R_AF, 0, 0);
        expect_term("fault", EXEC, 2, 32'hDEAD_DEAD, 1, 32'h3000, lat, sr);
        check("fault_lat", lat, 4);
        issue(EXEC, 32'h3000, R_DONE, 32'hCAFE_F00D, 1);
        expect_term("refetch", EXEC, 1, 32'hCAFE_F00D, 0, 32'h3000, lat, sr);
        check("refetch_req", sr, 1);

        issue(EXEC, 32'h2008, R_DONE, 32'h0020_0113, 1);
        expect_term("rf_flush", FLUSH, 2, 32'h0020_0113, 0, 32'h2008,
                    lat, sr);
        check("rf_flush_lat", lat, 4);
        sb.push_back('{R_DONE, 32'h0, 1'b0});
        expect_term("flush", FLUSH, 0, 0, 0, 0, lat, sr);
        check("flush_lat", lat, 17);
        check("flush_noreq", sr, 0);

        issue(EXEC, 32'h2000, R_DONE, 32'h0000_0013, 1);
        expect_term("post_flush", EXEC, 1, 32'h0000_0013, 0, 32'h2000,
                    lat, sr);
        check("post_flush_req", sr, 1);
        issue(EXEC, 32'h2040, R_DONE, 32'h0BAD_C0DE, 1);
        expect_term("alias", EXEC, 1, 32'h0BAD_C0DE, 0, 32'h2040, lat, sr);
        check("alias_req", sr, 1);
        issue(EXEC, 32'h2000, R_DONE, 32'h0000_0013, 1);
        expect_term("alias_back", EXEC, 1, 32'h0000_0013, 0, 32'h2000,
                    lat, sr);
        check("alias_back_req", sr, 1);

        c_cmd = EXEC;
        c_address = 32'h4000;
        tick();
        tick();
        check("rr_mreq_on", m_req, 1);
        rst_n = 1'b0;
        #1;
        check("rr_mreq_drop", m_req, 0);
        check("rr_resp", c_response, R_IDLE);
        m_ack = 1'b1;
        m_rdata = 32'h0000_0BAD;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c_cmd = NONE;
        m_ack = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("rr_init_done", c_reset_done, (i == 16));
        end

        issue(EXEC, 32'h4000, R_DONE, 32'h0030_0193, 1);
        expect_term("rr_after", EXEC, 1, 32'h0030_0193, 0, 32'h4000,
                    lat, sr);
        check("rr_after_req", sr, 1);
        c_cmd = NONE;
        tick();
        check("end_idle", c_response, R_IDLE);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
